// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage with integrated IF/ID register for the pipelined MIPS-DLX core.
// Drives a synchronous-read instruction memory so imem_rdata always lines up with pc_q.
module if_stage_pipe #(
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [DATA_W-1:0] NOP_WORD   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus_1,
  output logic              id_valid
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [ADDR_W-1:0] id_pc_plus_1_q, id_pc_plus_1_d;
  logic              id_valid_q, id_valid_d;

  assign pc_inc = pc_q + ONE;

  // Redirect beats stall; PC waits at RESET_ADDR until the first fetch is issued.
  always_comb begin
    pc_d          = pc_q;
    fetch_valid_d = 1'b1;
    if (redirect) begin
      pc_d = redirect_addr;
    end else if (stall || !fetch_valid_q) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_inc;
    end
  end

  // The memory latches the next PC, so its data is valid alongside pc_q.
  assign imem_addr = reset ? RESET_ADDR : pc_d;

  always_comb begin
    id_instr_d     = id_instr_q;
    id_pc_d        = id_pc_q;
    id_pc_plus_1_d = id_pc_plus_1_q;
    id_valid_d     = id_valid_q;
    if (redirect || flush) begin
      id_instr_d = NOP_WORD;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      id_instr_d     = imem_rdata;
      id_pc_d        = pc_q;
      id_pc_plus_1_d = pc_inc;
      id_valid_d     = fetch_valid_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_ADDR;
      fetch_valid_q  <= 1'b0;
      id_instr_q     <= NOP_WORD;
      id_pc_q        <= RESET_ADDR;
      id_pc_plus_1_q <= RESET_ADDR + ONE;
      id_valid_q     <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      fetch_valid_q  <= fetch_valid_d;
      id_instr_q     <= id_instr_d;
      id_pc_q        <= id_pc_d;
      id_pc_plus_1_q <= id_pc_plus_1_d;
      id_valid_q     <= id_valid_d;
    end
  end

  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign id_pc_plus_1 = id_pc_plus_1_q;
  assign id_valid     = id_valid_q;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Scoreboard bench for if_stage_pipe: a fetch-stream model predicts each IF/ID state,
// a monitor compares after every edge. Memory holds 0x1000_0000 + address.
module tb_if_stage_pipe;

  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  pc;
    logic [9:0]  pc1;
    logic        valid;
  } id_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, flush, redirect;
  logic [9:0]  redirect_addr;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [9:0]  id_pc, id_pc_plus_1;
  logic        id_valid;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  id_t        exp_q[$];
  logic [9:0] m_pc;
  logic       m_fv;
  id_t        m_id;

  if_stage_pipe #(
    .ADDR_W(10), .DATA_W(32), .RESET_ADDR(10'd0), .NOP_WORD(NOP)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus_1(id_pc_plus_1),
    .id_valid(id_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return 32'h1000_0000 + {22'd0, a};
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clock) imem_rdata <= mem_word(imem_addr);

  task automatic model_reset();
    m_pc = 10'd0;
    m_fv = 1'b0;
    m_id = '{instr: NOP, pc: 10'd0, pc1: 10'd1, valid: 1'b0};
  endtask

  // Applies one cycle of control inputs and predicts imem_addr and the IF/ID state after the edge.
  task automatic drive(input logic s, input logic f, input logic r, input logic [9:0] a);
    logic [9:0] nxt;
    logic [9:0] pc1;
    id_t        e;
    stall = s; flush = f; redirect = r; redirect_addr = a;
    pc1 = m_pc + 10'd1;
    if (r)              nxt = a;
    else if (s || !m_fv) nxt = m_pc;
    else                nxt = pc1;
    #1;
    checks++;
    if (imem_addr !== nxt) begin
      errors++;
      $display("FAIL imem_addr: got %h, expected %h", imem_addr, nxt);
    end
    if (r || f) begin
      e = m_id;
      e.instr = NOP;
      e.valid = 1'b0;
    end else if (s) begin
      e = m_id;
    end else begin
      e = '{instr: mem_word(m_pc), pc: m_pc, pc1: pc1, valid: m_fv};
    end
    exp_q.push_back(e);
    m_id = e;
    m_pc = nxt;
    m_fv = 1'b1;
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (id_instr !== NOP || id_pc !== 10'd0 || id_pc_plus_1 !== 10'd1 ||
        id_valid !== 1'b0 || imem_addr !== 10'd0) begin
      errors++;
      $display("FAIL %s: got instr=%h pc=%h pc1=%h v=%b addr=%h, expected instr=%h pc=000 pc1=001 v=0 addr=000",
               tag, id_instr, id_pc, id_pc_plus_1, id_valid, imem_addr, NOP);
    end
  endtask

  // Monitor: one IF/ID state observed and compared after every non-reset edge.
  initial begin
    id_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        txn++;
        $display("txn %0d: id_pc=%h id_pc_plus_1=%h id_instr=%h id_valid=%b",
                 txn, id_pc, id_pc_plus_1, id_instr, id_valid);
        if (id_instr !== e.instr || id_pc !== e.pc || id_pc_plus_1 !== e.pc1 || id_valid !== e.valid) begin
          errors++;
          $display("FAIL id_slot txn %0d: got instr=%h pc=%h pc1=%h v=%b, expected instr=%h pc=%h pc1=%h v=%b",
                   txn, id_instr, id_pc, id_pc_plus_1, id_valid, e.instr, e.pc, e.pc1, e.valid);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_addr = 10'd0;
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_state");
    reset = 1'b0;

    // Run-in: E1 bubble, then pcs 0..4 reach ID.
    idle(6);
    // Stall for three edges with pc 4 held in ID, then resume with 5, 6, 7.
    repeat (3) drive(1'b1, 1'b0, 1'b0, 10'd0);
    idle(3);
    // Redirect from pc 7 to 0x200.
    drive(1'b0, 1'b0, 1'b1, 10'h200);
    idle(2);
    // Redirect together with stall.
    drive(1'b1, 1'b0, 1'b1, 10'h050);
    idle(2);
    // Flush-only drops exactly one instruction.
    drive(1'b0, 1'b1, 1'b0, 10'd0);
    idle(3);
    // PC wrap at the top of the address space.
    drive(1'b0, 1'b0, 1'b1, 10'h3FF);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, 10'($urandom_range(0, 1023)));
    end
    idle(2);

    // Asynchronous reset between edges.
    stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_hold");
    reset = 1'b0;
    idle(6);
    for (int i = 0; i < 50; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, 10'($urandom_range(0, 1023)));
    end
    idle(1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
